// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encodings, port-select
// constants and the implemented memory depth shared with the data memory.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int DMEM_WORDS = 500;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin grant: a lone requester wins outright, a tie goes to
// the port that did not win last time. Purely combinational.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic i_req_cpu,
  input  logic i_req_dbg,
  input  logic i_last_grant,
  output logic o_grant,
  output logic o_grant_vld
);

  always_comb begin
    o_grant_vld = i_req_cpu | i_req_dbg;
    if (i_req_cpu && i_req_dbg) begin
      o_grant = (i_last_grant == PORT_CPU) ? PORT_DBG : PORT_CPU;
    end else if (i_req_dbg) begin
      o_grant = PORT_DBG;
    end else begin
      o_grant = PORT_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/debug arbiter and sequencer for the single-ported data memory; one access
// per three cycles. Optional DMEM_BOUNDS_CHECK_EN blocks out-of-range accesses.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_WORDS = DMEM_WORDS,
  parameter int DATA_W    = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [31:0]       cpuAddr,
  input  logic [DATA_W-1:0] cpuWData,
  output logic              cpuAck,
  output logic [DATA_W-1:0] cpuRData,
  input  logic              dbgReq,
  input  logic              dbgWe,
  input  logic [31:0]       dbgAddr,
  input  logic [DATA_W-1:0] dbgWData,
  output logic              dbgAck,
  output logic [DATA_W-1:0] dbgRData,
  output logic [31:0]       memAddr,
  output logic [DATA_W-1:0] memWData,
  output logic              memWrite,
  output logic              memRead,
  input  logic [DATA_W-1:0] memRData,
  output logic              busyDbg,
  output logic              errAddr
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_grant;
  logic              r_grant;
  logic              r_we;
  logic              r_oob;
  logic [31:0]       r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_write;
  logic              r_mem_read;
  logic              r_cpu_ack;
  logic              r_dbg_ack;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;

  logic              w_grant;
  logic              w_grant_vld;
  logic              w_sel_we;
  logic              w_oob;
  logic [31:0]       w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  rr_arb2 u_arb (
    .i_req_cpu    (cpuReq),
    .i_req_dbg    (dbgReq),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_vld  (w_grant_vld)
  );

  assign w_sel_addr  = (w_grant == PORT_DBG) ? dbgAddr  : cpuAddr;
  assign w_sel_wdata = (w_grant == PORT_DBG) ? dbgWData : cpuWData;
  assign w_sel_we    = (w_grant == PORT_DBG) ? dbgWe    : cpuWe;

`ifdef DMEM_BOUNDS_CHECK_EN
  logic r_err;

  assign w_oob = (w_sel_addr >= 32'(MEM_WORDS));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_err <= 1'b0;
    end else if (r_state == IDLE && w_grant_vld && w_oob) begin
      r_err <= 1'b1;
    end
  end

  assign errAddr = r_err;
`else
  assign w_oob   = 1'b0;
  assign errAddr = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant_vld) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = ACK;
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_last_grant <= PORT_DBG;
      r_grant      <= PORT_CPU;
      r_we         <= 1'b0;
      r_oob        <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_dbg_ack    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_dbg_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
          r_mem_write <= 1'b0;
          r_mem_read  <= 1'b0;
          if (w_grant_vld) begin
            r_grant      <= w_grant;
            r_last_grant <= w_grant;
            r_we         <= w_sel_we;
            r_oob        <= w_oob;
            r_mem_addr   <= w_sel_addr;
            r_mem_wdata  <= w_sel_wdata;
            r_mem_write  <= w_sel_we & ~w_oob;
            r_mem_read   <= ~w_sel_we & ~w_oob;
          end
        end
        ACCESS: begin
          r_mem_write <= 1'b0;
          r_mem_read  <= 1'b0;
          r_cpu_ack   <= (r_grant == PORT_CPU);
          r_dbg_ack   <= (r_grant == PORT_DBG);
          // Only reads capture; a blocked out-of-range read returns zero.
          if (!r_we) begin
            if (r_grant == PORT_CPU) r_cpu_rdata <= r_oob ? '0 : memRData;
            else                     r_dbg_rdata <= r_oob ? '0 : memRData;
          end
        end
        default: ;
      endcase
    end
  end

  assign memAddr  = r_mem_addr;
  assign memWData = r_mem_wdata;
  assign memWrite = r_mem_write;
  assign memRead  = r_mem_read;
  assign cpuAck   = r_cpu_ack;
  assign dbgAck   = r_dbg_ack;
  assign cpuRData = r_cpu_rdata;
  assign dbgRData = r_dbg_rdata;
  assign busyDbg  = (r_state != IDLE) && (r_grant == PORT_DBG);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed latency/priority/reset cases, then random
// two-port traffic against a transaction-level schedule and memory model.
module tb_dmem_arbiter;

  localparam int MW = 500;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        cpuReq = 1'b0, cpuWe = 1'b0;
  logic [31:0] cpuAddr = '0, cpuWData = '0;
  logic        dbgReq = 1'b0, dbgWe = 1'b0;
  logic [31:0] dbgAddr = '0, dbgWData = '0;
  logic        cpuAck, dbgAck, memWrite, memRead, busyDbg, errAddr;
  logic [31:0] cpuRData, dbgRData, memAddr, memWData, memRData;

  int n_chk = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  dmem_arbiter dut (
    .Clk(Clk), .Rst(Rst),
    .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
    .cpuAck(cpuAck), .cpuRData(cpuRData),
    .dbgReq(dbgReq), .dbgWe(dbgWe), .dbgAddr(dbgAddr), .dbgWData(dbgWData),
    .dbgAck(dbgAck), .dbgRData(dbgRData),
    .memAddr(memAddr), .memWData(memWData), .memWrite(memWrite), .memRead(memRead),
    .memRData(memRData), .busyDbg(busyDbg), .errAddr(errAddr)
  );

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h01010101) ^ 32'hA5A50000;
  endfunction

  // Bench-side memory: combinational read, write at the clock edge.
  logic [31:0] dmem [MW];
  logic        fill = 1'b0;
  logic        pl_we = 1'b0;
  logic [8:0]  pl_addr = '0;
  logic [31:0] pl_dat = '0;

  always @(posedge Clk) begin
    if (fill) begin
      for (int i = 0; i < MW; i++) dmem[i] <= pat(i);
    end else if (pl_we) begin
      dmem[pl_addr] <= pl_dat;
    end else if (memWrite && memAddr < 32'(MW)) begin
      dmem[memAddr[8:0]] <= memWData;
    end
  end

  assign memRData = (memAddr < 32'(MW)) ? dmem[memAddr[8:0]] : 32'hBAD0BAD0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".cpuAck"},   32'(cpuAck),   32'd0);
    chk({tag, ".dbgAck"},   32'(dbgAck),   32'd0);
    chk({tag, ".cpuRData"}, cpuRData,      32'd0);
    chk({tag, ".dbgRData"}, dbgRData,      32'd0);
    chk({tag, ".memAddr"},  memAddr,       32'd0);
    chk({tag, ".memWData"}, memWData,      32'd0);
    chk({tag, ".memWrite"}, 32'(memWrite), 32'd0);
    chk({tag, ".memRead"},  32'(memRead),  32'd0);
    chk({tag, ".busyDbg"},  32'(busyDbg),  32'd0);
    chk({tag, ".errAddr"},  32'(errAddr),  32'd0);
  endtask

  // Reset with memory refill; leaves the bench at posedge+3 with Rst released.
  task automatic do_reset(input string tag);
    #2 Rst = 1'b0;
    #1 chk_all_zero(tag);
    fill = 1'b1;
    step();
    fill = 1'b0;
    #2 Rst = 1'b1;
  endtask

  // Random-phase model state
  int          free_at, g_edge, n_gr, n_bad;
  logic        g_port, g_we, last, acc, ackc, pp;
  logic [31:0] g_addr, g_wdata, g_rd;
  logic [31:0] exp_rd [2];
  logic [31:0] ref_mem [MW];
  logic        pend [2], t_we [2], d_req [2], d_we [2];
  logic [31:0] t_addr [2], t_wdata [2], d_addr [2], d_wdata [2];

  task automatic drive();
    cpuReq = d_req[0]; cpuWe = d_we[0]; cpuAddr = d_addr[0]; cpuWData = d_wdata[0];
    dbgReq = d_req[1]; dbgWe = d_we[1]; dbgAddr = d_addr[1]; dbgWData = d_wdata[1];
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #2 Rst = 1'b0;
    #2 chk_all_zero("rst0");
    fill = 1'b1;
    step();
    fill = 1'b0;
    step();
    #2 Rst = 1'b1;

    // Both ports requesting continuously: CPU wins first tie, then alternation
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 32'd1;
    dbgReq = 1'b1; dbgWe = 1'b0; dbgAddr = 32'd2;
    for (int j = 0; j < 18; j++) begin
      step();
      chk("tie.memRead", 32'(memRead), 32'(j % 3 == 0));
      if (j % 3 == 0) chk("tie.memAddr", memAddr, ((j / 3) % 2 == 0) ? 32'd1 : 32'd2);
      chk("tie.cpuAck", 32'(cpuAck), 32'((j % 3 == 1) && ((j / 3) % 2 == 0)));
      chk("tie.dbgAck", 32'(dbgAck), 32'((j % 3 == 1) && ((j / 3) % 2 == 1)));
      chk("tie.busyDbg", 32'(busyDbg), 32'((j % 3 != 2) && ((j / 3) % 2 == 1)));
    end
    cpuReq = 1'b0; dbgReq = 1'b0;
    chk("tie.cpuRData", cpuRData, pat(1));
    chk("tie.dbgRData", dbgRData, pat(2));

    // Single CPU read of addr 5 holding DEADBEEF
    pl_addr = 9'd5; pl_dat = 32'hDEADBEEF; pl_we = 1'b1;
    step();
    pl_we = 1'b0;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 32'd5;
    step();
    chk("rd5.memRead", 32'(memRead), 32'd1);
    chk("rd5.memAddr", memAddr, 32'd5);
    chk("rd5.ack_early", 32'(cpuAck), 32'd0);
    step();
    chk("rd5.cpuAck", 32'(cpuAck), 32'd1);
    chk("rd5.memRead_off", 32'(memRead), 32'd0);
    chk("rd5.cpuRData", cpuRData, 32'hDEADBEEF);
    chk("rd5.dbgAck", 32'(dbgAck), 32'd0);
    cpuReq = 1'b0;
    step();
    chk("rd5.ack_pulse", 32'(cpuAck), 32'd0);
    chk("rd5.hold", cpuRData, 32'hDEADBEEF);

    // Debug write addr 10, then CPU read it back
    dbgReq = 1'b1; dbgWe = 1'b1; dbgAddr = 32'd10; dbgWData = 32'h12345678;
    step();
    chk("dwr.memWrite", 32'(memWrite), 32'd1);
    chk("dwr.memWData", memWData, 32'h12345678);
    chk("dwr.busy1", 32'(busyDbg), 32'd1);
    step();
    chk("dwr.memWrite_off", 32'(memWrite), 32'd0);
    chk("dwr.busy2", 32'(busyDbg), 32'd1);
    chk("dwr.dbgAck", 32'(dbgAck), 32'd1);
    chk("dwr.rdata_kept", dbgRData, pat(2));
    dbgReq = 1'b0;
    step();
    chk("dwr.busy_off", 32'(busyDbg), 32'd0);
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 32'd10;
    step();
    step();
    chk("rd10.cpuAck", 32'(cpuAck), 32'd1);
    chk("rd10.cpuRData", cpuRData, 32'h12345678);
    cpuReq = 1'b0;
    step();

    // Request dropped and inputs changed during ACCESS
    cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 32'd7; cpuWData = 32'hAAAA5555;
    step();
    cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = 32'd8; cpuWData = 32'h0BADF00D;
    step();
    chk("drop.cpuAck", 32'(cpuAck), 32'd1);
    chk("drop.rdata_kept", cpuRData, 32'h12345678);
    step();
    chk("drop.mem7", dmem[7], 32'hAAAA5555);
    chk("drop.mem8", dmem[8], pat(8));

    // Reset asserted mid-ACCESS of a CPU write to addr 3
    cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 32'd3; cpuWData = 32'h33333333;
    step();
    chk("rstmid.memWrite_pre", 32'(memWrite), 32'd1);
    #2 Rst = 1'b0;
    #1 chk_all_zero("rstmid");
    cpuReq = 1'b0;
    step();
    chk("rstmid.mem3", dmem[3], pat(3));
    #2 Rst = 1'b1;
    step();
    chk("rstmid.idle_write", 32'(memWrite), 32'd0);
    chk("rstmid.idle_ack", 32'(cpuAck), 32'd0);
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 32'd3;
    step();
    step();
    chk("rstmid.rd3_ack", 32'(cpuAck), 32'd1);
    chk("rstmid.rd3", cpuRData, pat(3));
    cpuReq = 1'b0;
    step();

`ifdef DMEM_BOUNDS_CHECK_EN
    dbgReq = 1'b1; dbgWe = 1'b1; dbgAddr = 32'd600; dbgWData = 32'hFFFF0000;
    step();
    chk("oob.memWrite", 32'(memWrite), 32'd0);
    chk("oob.errAddr", 32'(errAddr), 32'd1);
    step();
    chk("oob.dbgAck", 32'(dbgAck), 32'd1);
    chk("oob.memWrite2", 32'(memWrite), 32'd0);
    dbgReq = 1'b0;
    step();
    chk("oob.sticky", 32'(errAddr), 32'd1);
`else
    chk("noerr.errAddr", 32'(errAddr), 32'd0);
`endif

    // Random traffic against the transaction-level model
    do_reset("rst_rand");
    for (int i = 0; i < MW; i++) ref_mem[i] = pat(i);
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; d_req[p] = 1'b0; d_we[p] = 1'b0;
      d_addr[p] = '0; d_wdata[p] = '0; exp_rd[p] = '0;
    end
    drive();
    free_at = 0; g_edge = -100; last = 1'b1; n_gr = 0;
    g_port = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0; g_rd = '0;

    for (int e = 0; e < 3000; e++) begin
      step();
      // An idle arbiter grants at this edge; ties go to the other port.
      if (e >= free_at && (d_req[0] || d_req[1])) begin
        pp      = (d_req[0] && d_req[1]) ? ~last : ~d_req[0];
        g_port  = pp;
        g_edge  = e;
        g_we    = t_we[pp];
        g_addr  = t_addr[pp];
        g_wdata = t_wdata[pp];
        last    = pp;
        free_at = e + 3;
        n_gr++;
        if (g_we) ref_mem[g_addr[8:0]] = g_wdata;
        else      g_rd = ref_mem[g_addr[8:0]];
      end
      acc  = (e == g_edge);
      ackc = (e == g_edge + 1);
      if (ackc && !g_we) exp_rd[g_port] = g_rd;

      chk("rnd.memWrite", 32'(memWrite), 32'(acc && g_we));
      chk("rnd.memRead",  32'(memRead),  32'(acc && !g_we));
      if (acc) chk("rnd.memAddr", memAddr, g_addr);
      if (acc && g_we) chk("rnd.memWData", memWData, g_wdata);
      chk("rnd.cpuAck",   32'(cpuAck),  32'(ackc && g_port == 1'b0));
      chk("rnd.dbgAck",   32'(dbgAck),  32'(ackc && g_port == 1'b1));
      chk("rnd.busyDbg",  32'(busyDbg), 32'((acc || ackc) && g_port == 1'b1));
      chk("rnd.cpuRData", cpuRData, exp_rd[0]);
      chk("rnd.dbgRData", dbgRData, exp_rd[1]);
      chk("rnd.errAddr",  32'(errAddr), 32'd0);
      if (ackc && g_we) chk("rnd.memcommit", dmem[g_addr[8:0]], g_wdata);

      for (int p = 0; p < 2; p++) begin
        if (ackc && g_port == 1'(p)) begin
          pend[p]  = 1'b0;
          d_req[p] = 1'b0;
        end else if (acc && g_port == 1'(p)) begin
          if ($urandom_range(0, 1) == 1) begin
            d_we[p]    = 1'($urandom_range(0, 1));
            d_addr[p]  = $urandom_range(0, MW - 1);
            d_wdata[p] = $urandom;
          end
          if ($urandom_range(0, 3) == 0) d_req[p] = 1'b0;
        end
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p]    = 1'b1;
          t_we[p]    = 1'($urandom_range(0, 1));
          t_addr[p]  = $urandom_range(0, MW - 1);
          t_wdata[p] = $urandom;
          d_req[p]   = 1'b1;
          d_we[p]    = t_we[p];
          d_addr[p]  = t_addr[p];
          d_wdata[p] = t_wdata[p];
        end
      end
      drive();
    end

    d_req[0] = 1'b0; d_req[1] = 1'b0;
    drive();
    step(); step(); step();
    chk("rnd.activity", 32'(n_gr > 300), 32'd1);
    n_bad = 0;
    for (int i = 0; i < MW; i++) if (dmem[i] !== ref_mem[i]) n_bad++;
    chk("rnd.mem_final", 32'(n_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
